// File: rtl/mem_indata_sel_buf_pkg.sv
// Shared defaults and select-code names for the memory input-data selector.
// Pure constants, no latency; no flow control.
package memin_pkg;

    localparam int          MEMIN_DATA_W_DEF = 17;
    localparam int          MEMIN_SEL_W_DEF  = 3;
    localparam logic [31:0] MEMIN_CONST_DEF  = 32'd10;

    typedef enum logic [MEMIN_SEL_W_DEF-1:0] {
        SEL_SRC0  = 3'd0,
        SEL_SRC1  = 3'd1,
        SEL_CONST = 3'd2
    } memin_sel_e;

endpackage

// File: rtl/mem_indata_sel_buf_if.sv
// Request/drain bundle between datapath, selector buffer and data memory.
// Wiring only, no latency; in_ready/out_ready carry the backpressure.
interface mem_indata_sel_buf_if #(
    parameter int DATA_W  = 17,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 3,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;
    logic [CNT_W-1:0]          count;

    modport master (
        output src_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err, count
    );

    modport slave (
        input  src_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err, count
    );

endinterface

// File: rtl/mem_indata_sel_buf_fifo.sv
// Write-data buffer: DEPTH-entry storage, wrapping pointers and occupancy.
// Latency: written word visible at the head one cycle after the write edge.
// Backpressure: wr_rdy drops when full; ignored writes/reads are masked here.
module memin_fifo #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_dat,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_dat,
    output logic                       rd_vld,
    output logic                       wr_rdy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign wr_rdy = (count != (PW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign do_wr  = wr_en && wr_rdy;
    assign do_rd  = rd_en && rd_vld;
    assign rd_dat = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_indata_sel_buf.sv
// Selects a source word (or constant under MEMIN_CONST_SEL_EN) and queues it for data memory.
// Latency: one cycle from accepted request to out_valid when the buffer is empty.
// Backpressure: in_ready = not full (registered state only); out_ready drains the head.
module mem_indata_sel_buf
    import memin_pkg::*;
#(
    parameter int          DATA_W    = MEMIN_DATA_W_DEF,
    parameter int          NUM_SRC   = 2,
    parameter int          SEL_W     = MEMIN_SEL_W_DEF,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] CONST_VAL = MEMIN_CONST_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_indata_sel_buf_if.slave  bus
);
    logic              sel_legal;
    logic              push_hs;
    logic [DATA_W-1:0] sel_word;
    logic [DATA_W-1:0] fifo_dat;
    logic              fifo_vld;
    logic              fifo_rdy;
    logic              sel_err_q;

`ifdef MEMIN_CONST_SEL_EN
    assign sel_legal = (bus.sel <= SEL_W'(NUM_SRC));
`else
    assign sel_legal = (bus.sel < SEL_W'(NUM_SRC));
`endif

    // Constant is the fall-through word; it only lands in the buffer when its code is legal.
    always_comb begin
        sel_word = DATA_W'(CONST_VAL);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) sel_word = bus.src_data[k*DATA_W +: DATA_W];
        end
    end

    assign push_hs = bus.in_valid && fifo_rdy;

    memin_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push_hs && sel_legal),
        .wr_dat (sel_word),
        .rd_en  (bus.out_ready),
        .rd_dat (fifo_dat),
        .rd_vld (fifo_vld),
        .wr_rdy (fifo_rdy),
        .count  (bus.count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_err_q <= 1'b0;
        else     sel_err_q <= push_hs && !sel_legal;
    end

    assign bus.in_ready  = fifo_rdy;
    assign bus.out_valid = fifo_vld;
    assign bus.out_data  = fifo_vld ? fifo_dat : '0;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mem_indata_sel_buf.sv
// Directed plus random checks of mem_indata_sel_buf against a queue model.
module tb_mem_indata_sel_buf;
    import memin_pkg::*;

    localparam int DATA_W  = 17;
    localparam int NUM_SRC = 2;
    localparam int SEL_W   = 3;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_indata_sel_buf_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH)) bus ();

    mem_indata_sel_buf #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH),
                         .CONST_VAL(MEMIN_CONST_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] model_q [$];
    logic              exp_err = 1'b0;

    function automatic bit is_legal(input logic [SEL_W-1:0] s);
`ifdef MEMIN_CONST_SEL_EN
        return (int'(s) <= NUM_SRC);
`else
        return (int'(s) < NUM_SRC);
`endif
    endfunction

    function automatic logic [DATA_W-1:0] pick_word(input logic [SEL_W-1:0] s,
                                                   input logic [NUM_SRC*DATA_W-1:0] d);
        logic [NUM_SRC*DATA_W-1:0] sh;
        if (int'(s) < NUM_SRC) begin
            sh = d >> (int'(s) * DATA_W);
            return sh[DATA_W-1:0];
        end
        return DATA_W'(MEMIN_CONST_DEF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"},     32'(bus.count), 32'(sz));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sz > 0));
        chk({tag, ".out_data"},  32'(bus.out_data), (sz > 0) ? 32'(model_q[0]) : 32'd0);
        chk({tag, ".in_ready"},  32'(bus.in_ready), 32'(sz < DEPTH));
        chk({tag, ".sel_err"},   32'(bus.sel_err), 32'(exp_err));
    endtask

    task automatic cycle(input string tag);
        bit acc, pop, leg;
        logic [DATA_W-1:0] w;
        acc = bus.in_valid && (model_q.size() < DEPTH);
        pop = bus.out_ready && (model_q.size() > 0);
        leg = is_legal(bus.sel);
        w   = pick_word(bus.sel, bus.src_data);
        @(posedge clk);
        #1;
        if (pop) void'(model_q.pop_front());
        if (acc && leg) model_q.push_back(w);
        exp_err = acc && !leg;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] s,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1, input logic rdy);
        bus.in_valid  = v;
        bus.sel       = s;
        bus.src_data  = {d1, d0};
        bus.out_ready = rdy;
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return DATA_W'($urandom);
    endfunction

    initial begin
        drive(1'b0, '0, '0, '0, 1'b0);
        #1;
        check_outputs("reset0");
        repeat (2) @(negedge clk);
        check_outputs("reset_hold");
        rst = 1'b0;

        // Two sources queued behind a stalled memory, then drained in order.
        drive(1'b1, SEL_SRC0, 17'h00AAA, 17'h00000, 1'b0);
        cycle("t2_push0");
        drive(1'b1, SEL_SRC1, 17'h00000, 17'h1F0F0, 1'b0);
        cycle("t2_push1");
        chk("t2_count", 32'(bus.count), 32'd2);
        chk("t2_head", 32'(bus.out_data), 32'h00AAA);
        drive(1'b0, '0, '0, '0, 1'b1);
        cycle("t2_pop0");
        chk("t2_second", 32'(bus.out_data), 32'h1F0F0);
        cycle("t2_pop1");
        chk("t2_empty", 32'(bus.out_valid), 32'd0);

        // Fill to DEPTH, refuse a fifth request, then one pop reopens the input.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, SEL_W'(i % 2), rnd_word(), rnd_word(), 1'b0);
            cycle("t3_fill");
        end
        chk("t3_full_count", 32'(bus.count), 32'd4);
        chk("t3_full_rdy", 32'(bus.in_ready), 32'd0);
        drive(1'b1, SEL_SRC0, rnd_word(), rnd_word(), 1'b0);
        cycle("t3_fifth");
        chk("t3_fifth_count", 32'(bus.count), 32'd4);
        drive(1'b0, SEL_SRC0, '0, '0, 1'b1);
        cycle("t3_pop");
        chk("t3_pop_count", 32'(bus.count), 32'd3);
        chk("t3_pop_rdy", 32'(bus.in_ready), 32'd1);
        repeat (3) cycle("t3_drain");

        // Steady push+pop at occupancy 2, long enough to wrap the pointers.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, SEL_SRC1, rnd_word(), rnd_word(), 1'b0);
            cycle("t4_prime");
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, SEL_W'($urandom_range(0, 1)), rnd_word(), rnd_word(), 1'b1);
            cycle("t4_stream");
            chk("t4_count2", 32'(bus.count), 32'd2);
        end
        drive(1'b0, '0, '0, '0, 1'b1);
        repeat (2) cycle("t4_drain");

        // Illegal code: handshake completes, nothing queued, one-cycle error pulse.
        drive(1'b1, 3'd7, rnd_word(), rnd_word(), 1'b0);
        cycle("t5_illegal");
        chk("t5_err", 32'(bus.sel_err), 32'd1);
        chk("t5_count", 32'(bus.count), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b0);
        cycle("t5_after");
        chk("t5_err_clear", 32'(bus.sel_err), 32'd0);

        // Constant-select code.
        drive(1'b1, SEL_CONST, rnd_word(), rnd_word(), 1'b0);
        cycle("t6_const");
`ifdef MEMIN_CONST_SEL_EN
        chk("t6_const_word", 32'(bus.out_data), 32'd10);
        chk("t6_const_err", 32'(bus.sel_err), 32'd0);
`else
        chk("t6_const_err", 32'(bus.sel_err), 32'd1);
        chk("t6_const_count", 32'(bus.count), 32'd0);
`endif
        drive(1'b0, '0, '0, '0, 1'b1);
        cycle("t6_drain");

        // Random traffic, mostly legal selects.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? SEL_W'($urandom_range(0, 7)) : SEL_W'($urandom_range(0, 1)),
                  rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
            cycle("rand");
        end
        drive(1'b0, '0, '0, '0, 1'b1);
        repeat (DEPTH) cycle("rand_drain");

        // Reset in the middle of a burst with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SEL_W'(i % 2), rnd_word(), rnd_word(), 1'b0);
            cycle("t1_fill");
        end
        chk("t1_pre_count", 32'(bus.count), 32'd3);
        drive(1'b0, '0, '0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_err = 1'b0;
        check_outputs("t1_async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, SEL_SRC0, 17'h15555, rnd_word(), 1'b0);
        cycle("t1_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
